// File: rtl/tmr_scrubber.sv
// Background 2-of-3 vote-and-repair scrubber for triplicated memories.
// Optional `TMR_SCRUB_AUTO_EN`: rescan automatically after PERIOD idle cycles.
module tmr_scrubber #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int CW     = 8,
  parameter int PERIOD = 1024
) (
  input  logic          c,
  input  logic          rn,
  input  logic          start,
  input  logic          hold,
  input  logic          clr,
  output logic          re,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd0,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [2:0]    we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_cnt,
  output logic [2:0]    rep_err,
  output logic [2:0]    dbg_state
);

  // Port protocol: re/we are single-cycle strobes that fire only while hold=0;
  // hold is the "not ready" side and freezes READ/WRITE; rd0..2 return the
  // word one cycle after the re strobe and are consumed in CMP.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (PERIOD < 2) begin : g_bad_period
    $error("tmr_scrubber: PERIOD must be at least 2");
  end

  logic [2:0]    state, state_nx;
  logic [AW-1:0] a;
  logic [DW-1:0] v, v_q;
  logic [2:0]    m, m_q;
  logic          go, last, wr_fire;

  assign v       = (rd0 & rd1) | (rd0 & rd2) | (rd1 & rd2);
  assign m       = {rd2 != v, rd1 != v, rd0 != v};
  assign last    = (a == {AW{1'b1}});
  assign wr_fire = (state == S_WRITE) && !hold;

`ifdef TMR_SCRUB_AUTO_EN
  localparam int ICW = $clog2(PERIOD + 1);
  logic [ICW-1:0] idle_cnt;

  assign go = start || (idle_cnt == ICW'(PERIOD - 1));

  // Counts only consecutive IDLE cycles; any scan start rearms it.
  always_ff @(posedge c or negedge rn) begin
    if (!rn)                                idle_cnt <= '0;
    else if ((state != S_IDLE) || go)       idle_cnt <= '0;
    else                                    idle_cnt <= idle_cnt + ICW'(1);
  end
`else
  assign go = start;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go) state_nx = S_READ;
      S_READ:  if (!hold) state_nx = S_CMP;
      S_CMP:   begin
        if (m != 3'b000) state_nx = S_WRITE;
        else             state_nx = last ? S_DONE : S_READ;
      end
      S_WRITE: if (!hold) state_nx = last ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state <= S_IDLE;
      a     <= '0;
      v_q   <= '0;
      m_q   <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && go) a <= '0;
      if (state == S_CMP) begin
        v_q <= v;
        m_q <= m;
        if ((m == 3'b000) && !last) a <= a + AW'(1);
      end
      if (wr_fire && !last) a <= a + AW'(1);
    end
  end

  // clr takes priority over a same-edge correction.
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      err_cnt <= '0;
      rep_err <= '0;
    end else if (clr) begin
      err_cnt <= '0;
      rep_err <= '0;
    end else if (wr_fire) begin
      if (err_cnt != {CW{1'b1}}) err_cnt <= err_cnt + CW'(1);
      rep_err <= rep_err | m_q;
    end
  end

  assign re        = (state == S_READ) && !hold;
  assign ra        = re ? a : '0;
  assign we        = wr_fire ? m_q : 3'b000;
  assign wa        = wr_fire ? a : '0;
  assign wd        = wr_fire ? v_q : '0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_tmr_scrubber.sv
// Bench for tmr_scrubber: replica memories, a voting reference model and a
// write scoreboard; directed cases then randomized scans with random hold.
module tb_tmr_scrubber;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam int DEPTH = 1 << AW;
`ifdef TMR_SCRUB_AUTO_EN
  localparam int PER = 16;
`else
  localparam int PER = 1024;
`endif

  logic          c = 1'b0;
  logic          rn = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          clr = 1'b0;
  logic          re;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd0 = '0, rd1 = '0, rd2 = '0;
  logic [2:0]    we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          busy, done;
  logic [CW-1:0] err_cnt;
  logic [2:0]    rep_err;
  logic [2:0]    dbg_state;

  tmr_scrubber #(.DW(DW), .AW(AW), .CW(CW), .PERIOD(PER)) dut (
    .c(c), .rn(rn), .start(start), .hold(hold), .clr(clr),
    .re(re), .ra(ra), .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .err_cnt(err_cnt), .rep_err(rep_err), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 c = ~c;
  int cyc = 0;
  always @(posedge c) cyc++;

  // replica memories: requests captured mid-cycle, served at the next edge
  logic [DW-1:0] mem0[DEPTH], mem1[DEPTH], mem2[DEPTH];
  logic          rq = 1'b0;
  logic [AW-1:0] rq_a = '0, wq_a = '0;
  logic [2:0]    wq = '0;
  logic [DW-1:0] wq_d = '0;

  always @(negedge c) begin
    rq = re; rq_a = ra; wq = we; wq_a = wa; wq_d = wd;
  end

  always @(posedge c) begin
    if (rq) begin
      rd0 = mem0[rq_a]; rd1 = mem1[rq_a]; rd2 = mem2[rq_a];
    end
    if (wq[0]) mem0[wq_a] = wq_d;
    if (wq[1]) mem1[wq_a] = wq_d;
    if (wq[2]) mem2[wq_a] = wq_d;
  end

  // scoreboard state and reference model
  int n_chk = 0;
  int n_err = 0;
  logic [AW+3+DW-1:0] exp_q[$];
  logic [AW+3+DW-1:0] mon_e;
  logic [CW-1:0] err_m = '0;
  logic [2:0]    rep_m = '0;
  bit done_seen = 1'b0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] vote(input logic [DW-1:0] x, y, z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  always @(negedge c) begin
    if (rn) begin
      if (hold) check("hold_quiet", {28'd0, re, we}, 32'd0);
      check("re_we_excl", {31'd0, re && (we != 3'b000)}, 32'd0);
      if (we != 3'b000) begin
        if (exp_q.size() == 0) check("unexp_we", {29'd0, we}, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("wr", {17'd0, wa, we, wd}, {17'd0, mon_e});
        end
      end else check("wr_idle", {20'd0, wa, wd}, 32'd0);
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  // One full scan: predict corrections from the replica contents, drive the
  // hold windows (offsets from the start cycle) and check the aftermath.
  task automatic run_scan(input int h0, input int h0n, input int h1, input int h1n,
                          input bit rnd, input bit clr_all, input bit chk_lat);
    logic [DW-1:0] vv[DEPTH];
    logic [DW-1:0] v;
    logic [2:0] m;
    int nerr, s, off, sum;
    nerr = 0;
    for (int a = 0; a < DEPTH; a++) begin
      v = vote(mem0[a], mem1[a], mem2[a]);
      vv[a] = v;
      m = {mem2[a] != v, mem1[a] != v, mem0[a] != v};
      if (m != 3'b000) begin
        exp_q.push_back({AW'(a), m, v});
        nerr++;
        if (!clr_all) rep_m = rep_m | m;
      end
    end
    done_seen = 1'b0;
    @(posedge c); #1;
    start = 1'b1; clr = clr_all; s = cyc;
    for (int g = 0; g < 3000; g++) begin
      @(posedge c); #1;
      if (done_seen) break;
      off = cyc - s;
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      hold  = rnd ? ($urandom_range(0, 3) == 0)
                  : ((off >= h0 && off < h0 + h0n) || (off >= h1 && off < h1 + h1n));
    end
    start = 1'b0; hold = 1'b0; clr = 1'b0;
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    if (chk_lat) check("done_lat", done_cyc - s, 33 + nerr + h0n + h1n);
    check("wr_left", exp_q.size(), 32'd0);
    exp_q.delete();
    if (clr_all) begin
      err_m = '0; rep_m = '0;
    end else begin
      sum = int'(err_m) + nerr;
      err_m = (sum > (1 << CW) - 1) ? {CW{1'b1}} : CW'(sum);
    end
    check("err_cnt", {24'd0, err_cnt}, {24'd0, err_m});
    check("rep_err", {29'd0, rep_err}, {29'd0, rep_m});
    check("busy_after", {31'd0, busy}, 32'd0);
    for (int a = 0; a < DEPTH; a++)
      check("mem_voted", {8'd0, mem0[a], mem1[a], mem2[a]}, {8'd0, vv[a], vv[a], vv[a]});
  endtask

  task automatic fill(input logic [DW-1:0] val);
    for (int a = 0; a < DEPTH; a++) begin
      mem0[a] = val; mem1[a] = val; mem2[a] = val;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, {12'd0, re, ra, we, wa, wd}, 32'd0);
    check({tag, "_stat"}, {19'd0, busy, done, err_cnt, rep_err}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] base, keep;
    int r, k;
    bit hit;
    fill(8'h00);
    rn = 1'b0;
    repeat (3) @(posedge c);
    #1;
    check_all_zero("reset");
`ifdef TMR_SCRUB_AUTO_EN
    begin
      int rel;
      rn = 1'b1; rel = cyc; hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge c); #1;
        if (busy) begin hit = 1'b1; break; end
      end
      check("auto_found", {31'd0, hit}, 32'd1);
      check("auto_lat", cyc - rel, 32'd16);
    end
`else
    @(posedge c); #1; rn = 1'b1;

    // clean scan
    fill(8'h5A);
    run_scan(-1, 0, -1, 0, 0, 0, 1);
    // single-replica errors at addresses 3 and 9
    mem1[3] = 8'h5B; mem2[9] = 8'h1A;
    run_scan(-1, 0, -1, 0, 0, 0, 1);
    // three-way disagreement, then a rescan that must be clean
    mem0[5] = 8'h0F; mem1[5] = 8'h3C; mem2[5] = 8'hF0;
    run_scan(-1, 0, -1, 0, 0, 0, 1);
    run_scan(-1, 0, -1, 0, 0, 0, 1);
    // hold for 4 cycles on READ of address 7, 2 cycles on the WRITE of address 9
    fill(8'h5A); mem2[9] = 8'h00;
    run_scan(15, 4, 25, 2, 0, 0, 1);

    // standalone clear
    @(posedge c); #1; clr = 1'b1;
    @(posedge c); #1; clr = 1'b0;
    err_m = '0; rep_m = '0;
    check("clr_err", {24'd0, err_cnt}, 32'd0);
    check("clr_rep", {29'd0, rep_err}, 32'd0);

    // clear held through a scan with corrections
    mem0[1] = 8'hFF; mem2[14] = 8'h00;
    run_scan(-1, 0, -1, 0, 0, 1, 1);

    // reset during WRITE: no partial write, next scan restarts at 0
    fill(8'h33); mem1[2] = 8'h32; mem0[10] = 8'hB3; keep = mem1[2];
    @(posedge c); #1; start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge c); #1; start = 1'b0;
      if (we != 3'b000) begin hit = 1'b1; break; end
    end
    check("found_write", {31'd0, hit}, 32'd1);
    rn = 1'b0; #1;
    check_all_zero("midrst");
    repeat (2) @(posedge c);
    check("no_partial_wr", {24'd0, mem1[2]}, {24'd0, keep});
    #1; rn = 1'b1;
    exp_q.delete(); err_m = '0; rep_m = '0;
    run_scan(-1, 0, -1, 0, 0, 0, 1);

    // randomized contents with random hold and stray start pulses
    for (int j = 0; j < 6; j++) begin
      for (int a = 0; a < DEPTH; a++) begin
        base = DW'($urandom);
        mem0[a] = base; mem1[a] = base; mem2[a] = base;
        r = $urandom_range(0, 9);
        k = $urandom_range(0, 2);
        if (r <= 3) begin
          if (k == 0) mem0[a] = base ^ DW'($urandom_range(1, 255));
          else if (k == 1) mem1[a] = base ^ DW'($urandom_range(1, 255));
          else mem2[a] = base ^ DW'($urandom_range(1, 255));
        end else if (r == 4) begin
          mem0[a] = base ^ 8'h01; mem2[a] = base ^ 8'h80;
        end else if (r == 5) begin
          mem0[a] = DW'($urandom); mem1[a] = DW'($urandom); mem2[a] = DW'($urandom);
        end
      end
      run_scan(-1, 0, -1, 0, 1, 0, 0);
    end

    // saturation: 256 corrections after a clear
    @(posedge c); #1; clr = 1'b1;
    @(posedge c); #1; clr = 1'b0;
    err_m = '0; rep_m = '0;
    for (int j = 0; j < 16; j++) begin
      for (int a = 0; a < DEPTH; a++) begin
        base = DW'($urandom);
        mem0[a] = base; mem1[a] = base; mem2[a] = base;
        k = (a + j) % 3;
        if (k == 0) mem0[a] = base ^ DW'(1 << (a % 8));
        else if (k == 1) mem1[a] = base ^ DW'(1 << (a % 8));
        else mem2[a] = base ^ DW'(1 << (a % 8));
      end
      run_scan(-1, 0, -1, 0, 0, 0, 1);
    end
    check("err_sat", {24'd0, err_cnt}, 32'd255);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
